// File: rtl/fifo_rd_adapter_pkg.sv
// Shared types for fifo_rd_adapter: buffer state encoding and word counter width.
package fifo_rd_adapter_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int WORD_CNT_W = 16;

  function automatic logic [1:0] occ_of(state_t s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      HALF:    occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/fifo_rd_adapter.sv
// FWFT async-FIFO read side to valid/ready stream via a 2-entry skid buffer; 1-cycle latency,
// rpull depends only on registered state and rempty. Optional word_cnt with FIFO_RD_ADAPTER_CNT_EN.
module fifo_rd_adapter
  import fifo_rd_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rpull,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
`ifdef FIFO_RD_ADAPTER_CNT_EN
  output logic [1:0]            occupancy,
  output logic [WORD_CNT_W-1:0] word_cnt
`else
  output logic [1:0]            occupancy
`endif
);

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic                  push;
  logic                  pop;
  logic                  ld_head_rdata;
  logic                  ld_head_tail;
  logic                  ld_tail;

  // Pull is never allowed in FULL, even when the consumer is draining this cycle,
  // so m_ready has no combinational path to the FIFO side.
  assign rpull     = !rempty && (state != FULL) && !rrst;
  assign push      = rpull;
  assign m_valid   = (state != EMPTY);
  assign pop       = m_valid && m_ready;
  assign m_data    = head;
  assign occupancy = occ_of(state);

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ld_head_rdata = 1'b0;
    ld_head_tail  = 1'b0;
    ld_tail       = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          state_nxt     = HALF;
          ld_head_rdata = 1'b1;
        end
      end
      HALF: begin
        if (push && pop) begin
          ld_head_rdata = 1'b1;
        end else if (push) begin
          state_nxt = FULL;
          ld_tail   = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_nxt    = HALF;
          ld_head_tail = 1'b1;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (ld_head_rdata) begin
        head <= rdata;
      end else if (ld_head_tail) begin
        head <= tail;
      end
      if (ld_tail) begin
        tail <= rdata;
      end
    end
  end

`ifdef FIFO_RD_ADAPTER_CNT_EN
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      word_cnt <= '0;
    end else if (pop) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Directed bench for fifo_rd_adapter with a queue-based FWFT FIFO on the read side.
module tb_fifo_rd_adapter;
  import fifo_rd_adapter_pkg::*;

  localparam int DW = 32;

  logic          rclk;
  logic          rrst;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rpull;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [1:0]    occupancy;
`ifdef FIFO_RD_ADAPTER_CNT_EN
  logic [WORD_CNT_W-1:0] word_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [DW-1:0] q[$];
  bit            stall = 1'b0;

  logic          s_rpull;
  logic          s_valid;
  logic          s_pop;
  logic [DW-1:0] s_data;
  logic [1:0]    s_occ;

  fifo_rd_adapter #(.DATA_WIDTH(DW)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rempty    (rempty),
    .rdata     (rdata),
    .rpull     (rpull),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
`ifdef FIFO_RD_ADAPTER_CNT_EN
    .occupancy (occupancy),
    .word_cnt  (word_cnt)
`else
    .occupancy (occupancy)
`endif
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // One cycle: present the FIFO head, sample outputs mid-low-phase, then let the edge pop.
  task automatic tick();
    rempty = (q.size() == 0) || stall;
    rdata  = (q.size() != 0) ? q[0] : '0;
    #1;
    s_rpull = rpull;
    s_valid = m_valid;
    s_data  = m_data;
    s_occ   = occupancy;
    s_pop   = m_valid && m_ready;
    @(posedge rclk);
    if (s_rpull) void'(q.pop_front());
    @(negedge rclk);
  endtask

  task automatic test_reset();
    rrst    = 1'b1;
    m_ready = 1'b1;
    q.delete();
    for (int i = 0; i < 4; i++) q.push_back(32'h99 + i);
    for (int c = 0; c < 3; c++) begin
      tick();
      total_cnt++;
      if (s_rpull !== 1'b0) $display("FAIL reset_rpull c%0d: got %b want 0", c, s_rpull);
      else pass_cnt++;
      total_cnt++;
      if (s_valid !== 1'b0) $display("FAIL reset_valid c%0d: got %b want 0", c, s_valid);
      else pass_cnt++;
      total_cnt++;
      if (s_occ !== 2'd0) $display("FAIL reset_occ c%0d: got %0d want 0", c, s_occ);
      else pass_cnt++;
      total_cnt++;
      if (s_data !== '0) $display("FAIL reset_data c%0d: got %0h want 0", c, s_data);
      else pass_cnt++;
    end
    q.delete();
    rrst = 1'b0;
  endtask

  task automatic test_stream();
    m_ready = 1'b1;
    for (int i = 2; i <= 17; i++) q.push_back(i);
    tick();
    total_cnt++;
    if (s_rpull !== 1'b1 || s_valid !== 1'b0)
      $display("FAIL stream_first: got rpull=%b valid=%b want rpull=1 valid=0", s_rpull, s_valid);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      tick();
      total_cnt++;
      if (s_valid !== 1'b1 || s_data !== DW'(i + 2))
        $display("FAIL stream_word%0d: got valid=%b data=%0d want valid=1 data=%0d",
                 i, s_valid, s_data, i + 2);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (s_valid !== 1'b0) $display("FAIL stream_drained: got valid=%b want 0", s_valid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int exp;
    m_ready = 1'b0;
    for (int i = 20; i <= 39; i++) q.push_back(i);
    tick();
    tick();
    total_cnt++;
    if (s_occ !== 2'd1 || s_data !== DW'(20))
      $display("FAIL bp_half: got occ=%0d data=%0d want occ=1 data=20", s_occ, s_data);
    else pass_cnt++;
    for (int c = 0; c < 4; c++) begin
      tick();
      total_cnt++;
      if (s_occ !== 2'd2 || s_rpull !== 1'b0 || s_data !== DW'(20))
        $display("FAIL bp_full c%0d: got occ=%0d rpull=%b data=%0d want occ=2 rpull=0 data=20",
                 c, s_occ, s_rpull, s_data);
      else pass_cnt++;
    end
    m_ready = 1'b1;
    tick();
    total_cnt++;
    if (s_rpull !== 1'b0 || s_pop !== 1'b1 || s_data !== DW'(20))
      $display("FAIL bp_release: got rpull=%b pop=%b data=%0d want rpull=0 pop=1 data=20",
               s_rpull, s_pop, s_data);
    else pass_cnt++;
    exp = 21;
    for (int c = 0; c < 60 && exp < 40; c++) begin
      tick();
      if (s_pop) begin
        total_cnt++;
        if (s_data !== DW'(exp)) $display("FAIL bp_order: got %0d want %0d", s_data, exp);
        else pass_cnt++;
        exp++;
      end
    end
    total_cnt++;
    if (exp !== 40) $display("FAIL bp_count: got next=%0d want 40", exp);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int            exp;
    logic          prev_hold;
    logic [DW-1:0] prev_data;
    exp       = 1000;
    prev_hold = 1'b0;
    prev_data = '0;
    for (int i = 1000; i < 1200; i++) q.push_back(i);
    for (int c = 0; c < 3000 && exp < 1200; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      stall   = ($urandom_range(0, 3) == 0);
      tick();
      total_cnt++;
      if (s_occ > 2'd2 || s_valid !== (s_occ != 2'd0))
        $display("FAIL rand_occ c%0d: got occ=%0d valid=%b want occ<=2 and valid=(occ!=0)",
                 c, s_occ, s_valid);
      else pass_cnt++;
      if (prev_hold && s_valid) begin
        total_cnt++;
        if (s_data !== prev_data)
          $display("FAIL rand_stable c%0d: got %0d want %0d", c, s_data, prev_data);
        else pass_cnt++;
      end
      if (s_pop) begin
        total_cnt++;
        if (s_data !== DW'(exp)) $display("FAIL rand_order: got %0d want %0d", s_data, exp);
        else pass_cnt++;
        exp++;
      end
      prev_hold = s_valid && !m_ready;
      prev_data = s_data;
    end
    stall = 1'b0;
    total_cnt++;
    if (exp !== 1200) $display("FAIL rand_count: got next=%0d want 1200", exp);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    m_ready = 1'b0;
    for (int i = 50; i <= 59; i++) q.push_back(i);
    for (int c = 0; c < 10; c++) begin
      tick();
      if (occupancy == 2'd2) break;
    end
    total_cnt++;
    if (occupancy !== 2'd2) $display("FAIL mrst_fill: got occ=%0d want 2", occupancy);
    else pass_cnt++;
    rrst = 1'b1;
    #1;
    total_cnt++;
    if (m_valid !== 1'b0 || occupancy !== 2'd0 || rpull !== 1'b0 || m_data !== '0)
      $display("FAIL mrst_async: got valid=%b occ=%0d rpull=%b data=%0h want 0 0 0 0",
               m_valid, occupancy, rpull, m_data);
    else pass_cnt++;
    @(posedge rclk);
    @(negedge rclk);
    rrst    = 1'b0;
    m_ready = 1'b1;
    tick();
    total_cnt++;
    if (s_valid !== 1'b0 || s_rpull !== 1'b1)
      $display("FAIL mrst_restart: got valid=%b rpull=%b want valid=0 rpull=1", s_valid, s_rpull);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (s_valid !== 1'b1 || s_data !== DW'(52))
      $display("FAIL mrst_head: got valid=%b data=%0d want valid=1 data=52", s_valid, s_data);
    else pass_cnt++;
    for (int c = 0; c < 20 && (q.size() != 0 || m_valid); c++) tick();
  endtask

`ifdef FIFO_RD_ADAPTER_CNT_EN
  task automatic test_counter();
    int pops;
    pops = 0;
    q.delete();
    rrst = 1'b1;
    @(posedge rclk);
    @(negedge rclk);
    rrst    = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 65537; i++) q.push_back(i);
    for (int c = 0; c < 70000 && pops < 65537; c++) begin
      tick();
      if (s_pop) pops++;
    end
    total_cnt++;
    if (pops !== 65537 || word_cnt !== 16'd1)
      $display("FAIL cnt_wrap: got pops=%0d word_cnt=%0d want pops=65537 word_cnt=1",
               pops, word_cnt);
    else pass_cnt++;
  endtask
`endif

  initial begin
    rrst    = 1'b1;
    rempty  = 1'b1;
    rdata   = '0;
    m_ready = 1'b0;
    @(negedge rclk);
    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_mid_reset();
`ifdef FIFO_RD_ADAPTER_CNT_EN
    test_counter();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_rd_adapter.md
FIFO_RD_ADAPTER -- requirements
Module: fifo_rd_adapter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of FIFO read data and stream data.
REQ-002 SHALL use one clock and an asynchronous, active-high reset.
REQ-003 SHALL have port rclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rrst, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port rempty, input, 1 bit: the asyncfifo read-side empty flag.
REQ-006 SHALL have port rdata, input, DATA_WIDTH: FIFO head word, first-word-fall-through, valid whenever rempty=0.
REQ-007 SHALL have port rpull, output, 1 bit: pop request to the FIFO; the head is consumed at the rclk edge where rpull=1.
REQ-008 SHALL have port m_valid, output, 1 bit: stream data valid.
REQ-009 SHALL have port m_ready, input, 1 bit: stream consumer ready.
REQ-010 SHALL have port m_data, output, DATA_WIDTH: stream data, the oldest buffered word.
REQ-011 SHALL have port occupancy, output, 2 bits: buffered word count, 0..2.

Function
REQ-012 SHALL hold a 2-entry in-order buffer with states EMPTY (0 words), HALF (1 word) and FULL (2 words).
REQ-013 SHALL drive rpull = !rempty && state!=FULL && !rrst, as combinational logic from registered state and rempty only; there SHALL be no path from m_ready to rpull.
REQ-014 SHALL capture rdata into the buffer tail at every rclk edge where rpull=1 (push).
REQ-015 SHALL drive m_valid = (state!=EMPTY) and m_data = the head entry, both from registers.
REQ-016 SHALL remove the head at every rclk edge where m_valid && m_ready (pop).
REQ-017 Transitions SHALL be: EMPTY -push-> HALF; HALF -push only-> FULL; HALF -pop only-> EMPTY; HALF -push and pop-> HALF with the new word at the head; FULL -pop-> HALF. All other cases SHALL hold state.
REQ-018 SHALL give a latency of 1 cycle: rempty falls in cycle T, so rpull=1 in T and m_valid=1 in T+1 with m_data = the rdata sampled at the end of T.
REQ-019 SHALL sustain 1 word/cycle while rempty=0 and m_ready=1 are held.
REQ-020 SHALL keep m_data stable while m_valid=1 and m_ready=0.
REQ-021 SHALL never push in FULL, even if m_ready=1 in that cycle; one cycle of bubble is acceptable.
REQ-022 SHALL keep the order of words out equal to the order of FIFO pops, with no drops and no duplicates.
REQ-023 occupancy SHALL equal 0, 1 or 2 for EMPTY, HALF or FULL respectively.

Reset
REQ-024 While rrst=1, SHALL force state=EMPTY, m_valid=0, occupancy=0 and rpull=0; m_data SHALL be 0.
REQ-025 On reset mid-operation, SHALL discard buffered words; after rrst deasserts, the first push SHALL occur no earlier than the first rclk edge with rrst=0.

Configuration
REQ-026 With macro FIFO_RD_ADAPTER_CNT_EN defined, SHALL add output word_cnt, 16 bits, reset to 0.
REQ-027 With FIFO_RD_ADAPTER_CNT_EN defined, word_cnt SHALL increment by 1 per pop and wrap from 0xFFFF to 0x0000.
REQ-028 Without FIFO_RD_ADAPTER_CNT_EN, the word_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 Package fifo_rd_adapter_pkg SHALL hold the state enum typedef (EMPTY/HALF/FULL) and the constant WORD_CNT_W=16.
REQ-030 The two-entry storage and FSM SHALL be inline; no sub-module.

Verification
REQ-031 Reset: hold rrst=1 for 3 cycles with rempty=0 -> rpull=0, m_valid=0, occupancy=0 throughout.
REQ-032 Streaming: FIFO preloaded with 2..17, m_ready=1 -> 16 words out in order 2..17 on consecutive cycles; first m_valid 1 cycle after the first rpull.
REQ-033 Backpressure: FIFO holds 20..39, m_ready=0 -> occupancy reaches 2, rpull=0 afterwards, m_data=20 held stable; release m_ready -> 20..39 out in order with no loss.
REQ-034 Random ready: 200 words with m_ready randomised at 50% and rempty toggling -> scoreboard exact match; occupancy never exceeds 2; no pop when m_valid=0.
REQ-035 Mid-operation reset: assert rrst while occupancy=2 -> m_valid=0 on the same cycle; after release, the next word out is the current FIFO head.
REQ-036 Counter (FIFO_RD_ADAPTER_CNT_EN): 65537 handshakes -> word_cnt=1; with the macro undefined the bench compiles without word_cnt.
